chip8_mem_ctrl: RTL

Parametrised CHIP-8 main-memory controller, successor to the plain byte memory: single-port synchronous RAM behind a valid/ready request interface. It self-initialises after reset by clearing RAM and loading the built-in hex font, and serves four operations:
- byte read
- byte write
- big-endian 16-bit opcode fetch
- burst read of up to 16 bytes, for Dxyn sprite fetch

It sits between the CPU core and the display/draw unit, and is the only owner of the memory array.

---
 rtl/chip8_pkg.sv | 28 ++
 rtl/chip8_font_rom.sv | 40 ++++
 rtl/chip8_mem_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
//==============================================================================
// Module  : chip8_pkg
// Brief   : Shared op encodings, font constants and controller state type.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package chip8_pkg;

    localparam logic [1:0] OP_RD_B  = 2'b00;
    localparam logic [1:0] OP_WR_B  = 2'b01;
    localparam logic [1:0] OP_RD_W  = 2'b10;
    localparam logic [1:0] OP_BURST = 2'b11;

    localparam int          FONT_LEN          = 80;
    localparam logic [11:0] FONT_BASE_DEFAULT = 12'h050;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WORD  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/chip8_font_rom.sv
//==============================================================================
// Module  : chip8_font_rom
// Brief   : Combinational 80x8 CHIP-8 hex font lookup; out-of-range reads 0.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module chip8_font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] index,
    output logic [7:0] row
);

    // Glyphs 0..F, five rows each, MSB = leftmost pixel
    localparam logic [0:FONT_LEN-1][7:0] FONT = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    assign row = (index < 7'(FONT_LEN)) ? FONT[index] : 8'h00;

endmodule

`default_nettype wire

// File: rtl/chip8_mem_ctrl.sv
//==============================================================================
// Module  : chip8_mem_ctrl
// Brief   : Single-port CHIP-8 RAM with self-init, byte/word/burst access.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module chip8_mem_ctrl
    import chip8_pkg::*;
#(
    parameter int          ADDR_W         = 12,
    parameter int          DATA_W         = 8,
    parameter int unsigned FONT_BASE      = 32'(FONT_BASE_DEFAULT),
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [3:0]          req_len,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_last,
    output logic                init_done
);

    localparam int                DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FONT_BASE_A = ADDR_W'(FONT_BASE);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic [3:0]        burst_rem;
    logic [DATA_W-1:0] word_hi;

    logic [ADDR_W-1:0] font_off;
    logic              in_font;
    logic [7:0]        font_row;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              accept;
    logic              load_hi;
    logic              rsp_valid_nxt;
    logic              rsp_last_nxt;
    logic              rsp_word;

    assign font_off = init_cnt - FONT_BASE_A;
    assign in_font  = (font_off < ADDR_W'(FONT_LEN));

    chip8_font_rom u_font_rom (
        .index (7'(font_off)),
        .row   (font_row)
    );

    assign req_ready = (state == ST_IDLE);
    assign rd_data   = mem[rd_addr];

    always_comb begin
        state_nxt     = state;
        mem_we        = 1'b0;
        mem_waddr     = req_addr;
        mem_wdata     = req_wdata;
        rd_addr       = req_addr;
        accept        = 1'b0;
        load_hi       = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_last_nxt  = 1'b0;
        rsp_word      = 1'b0;
        unique case (state)
            ST_INIT: begin
                mem_we    = CLEAR_ON_RESET || in_font;
                mem_waddr = init_cnt;
                mem_wdata = in_font ? DATA_W'(font_row) : '0;
                if (&init_cnt) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    unique case (req_op)
                        OP_RD_B: begin
                            rsp_valid_nxt = 1'b1;
                            rsp_last_nxt  = 1'b1;
                        end
                        OP_WR_B: mem_we = 1'b1;
                        OP_RD_W: begin
                            load_hi   = 1'b1;
                            state_nxt = ST_WORD;
                        end
                        default: begin
                            // First burst byte is read at acceptance
                            rsp_valid_nxt = 1'b1;
                            rsp_last_nxt  = (req_len == 4'd0);
                            if (req_len != 4'd0) state_nxt = ST_BURST;
                        end
                    endcase
                end
            end
            ST_WORD: begin
                rd_addr       = next_addr;
                rsp_valid_nxt = 1'b1;
                rsp_last_nxt  = 1'b1;
                rsp_word      = 1'b1;
                state_nxt     = ST_IDLE;
            end
            ST_BURST: begin
                rd_addr       = next_addr;
                rsp_valid_nxt = 1'b1;
                rsp_last_nxt  = (burst_rem == 4'd1);
                if (burst_rem == 4'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Array kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            next_addr <= '0;
            burst_rem <= '0;
            word_hi   <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_last  <= rsp_last_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (&init_cnt) init_done <= 1'b1;
            end
            if (rsp_valid_nxt)
                rsp_data <= rsp_word ? {word_hi, rd_data} : {{DATA_W{1'b0}}, rd_data};
            if (load_hi) word_hi <= rd_data;
            if (accept) begin
                next_addr <= req_addr + 1'b1;
                burst_rem <= req_len;
            end else if (state == ST_BURST) begin
                next_addr <= next_addr + 1'b1;
                burst_rem <= burst_rem - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
